bs_normalizer: RTL and testbench
================================

Name: bs_normalizer

Overview:
- Multi-cycle inverse of the barrel shifter. Given a data word, it finds the left-shift amount that brings the most significant set bit to bit DATA_W-1.
- Returns both the normalized word and that shift amount, so the amount can be fed back into the barrel shifter's shift_amt.
- Sits beside the barrel shifter in the shift datapath. Uses a valid/ready handshake on both sides and iterates a binary-search leading-zero count, one stage per clock.

Parameters:
- DATA_W, 32, data word width (power of two, >= 4).
- SHIFT_W, $clog2(DATA_W), width of shift_amt; also the number of iteration cycles.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a word.
- data_in  input  DATA_W  word to normalize.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- data_out  output  DATA_W  normalized word, equal to data_in << shift_amt.
- shift_amt  output  SHIFT_W  leading-zero count of data_in.
- zero  output  1  data_in was all zeros.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high, port name reset.
- While reset is asserted: state=IDLE; data_out, shift_amt and zero are 0; out_valid=0; in_ready=0.
- FSM has three states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !reset.
- out_valid = (state==DONE).
- IDLE:
  - On a clk edge with in_valid && in_ready: load work register w=data_in, clear acc=0, set stage k=SHIFT_W-1, go to SHIFT.
- SHIFT, one stage per cycle:
  - If w[DATA_W-1 -: 2^k]==0, then w <= w << 2^k and acc <= acc + 2^k.
  - If k==0, go to DONE; otherwise k <= k-1.
- Latency: out_valid rises SHIFT_W+1 edges after the accepting edge (6 for DATA_W=32).
- Throughput: one word per SHIFT_W+2 cycles, with no stall.
- DONE:
  - data_out=w, shift_amt=acc, zero=(w==0). All outputs are registered.
  - Outputs hold stable while out_ready=0, for any number of cycles.
  - When out_ready=1, the result is consumed at the edge and the FSM goes to IDLE.
- No overlap: in_ready=0 in SHIFT and DONE. in_valid is ignored there and the input word is not sampled.
- Zero input: all stages shift. Result is shift_amt=DATA_W-1 (31), data_out=0, zero=1.
- MSB already set: no stage shifts. Result is shift_amt=0, data_out=data_in, zero=0.
- acc never overflows, since its maximum is 2^SHIFT_W-1.
- After the DONE handshake, data_out, shift_amt and zero keep their last values (not cleared). Only out_valid qualifies them.
- Reset mid-operation: the FSM returns to IDLE immediately (asynchronous), any partial result is discarded, and outputs take their reset values.

Optional Feature:
- Macro: BS_NORM_EARLY_EXIT_EN.
- With the macro defined:
  - At the accepting edge, if data_in[DATA_W-1]==1 or data_in==0, the FSM goes straight to DONE, skipping SHIFT.
  - Results: MSB set gives shift_amt=0, data_out=data_in. Zero gives shift_amt=DATA_W-1, data_out=0, zero=1.
  - out_valid rises 1 edge after accept.
  - All other words follow the normal SHIFT_W-cycle path.
- Without the macro: every word takes SHIFT_W+1 edges to out_valid. Results are identical in all cases; only latency differs.

Decomposition:
- Package bs_pkg holds:
  - DATA_W_DEF=32 and SHIFT_W_DEF=5;
  - the FSM typedef bs_norm_state_t {IDLE, SHIFT, DONE}.
- The existing barrel shifter and this block both import it.
- One natural sub-module: bs_norm_stage, combinational.
  - Inputs: w, k.
  - Outputs: shifted w and a hit bit (shift performed).
- The top level instantiates one bs_norm_stage and reuses it every cycle under the FSM.

Test Plan:
1. data_in=0x0000_0001, out_ready=1 -> data_out=0x8000_0000, shift_amt=31, zero=0; out_valid exactly 6 edges after accept.
2. data_in=0x0001_2345 -> data_out=0x91A2_8000, shift_amt=15, zero=0.
3. data_in=0x8000_0000 -> data_out=0x8000_0000, shift_amt=0. Latency is 6 edges without the macro, 1 edge with BS_NORM_EARLY_EXIT_EN.
4. data_in=0x0000_0000 -> data_out=0, shift_amt=31, zero=1.
5. Backpressure:
   - Stimulus: out_ready=0 for 10 cycles in DONE, with in_valid=1 and data_in changing.
   - Required: outputs stable, in_ready=0, no new word taken.
   - Then raise out_ready=1: FSM in IDLE next cycle, in_ready=1, the next word is accepted.
6. Reset mid-operation:
   - Stimulus: assert reset 3 cycles after accepting 0x00F0_0000.
   - Required: out_valid=0 and outputs=0 immediately, without waiting for an edge.
   - After release: in_ready=1, and a new word 0x0000_0100 gives shift_amt=23, data_out=0x8000_0000.
7. Scoreboard: compare against a reference model, where shift_amt is the leading-zero count of data_in and data_out=data_in<<shift_amt. Run 1000 random words with random out_ready stalls.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and defaults for the shift datapath (barrel shifter and normalizer).
package bs_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SHIFT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bs_norm_state_t;

endpackage

// File: rtl/bs_normalizer_if.sv
// Valid/ready bus of the normalizer: the slave modport is the block, the master modport
// is whoever feeds it words and consumes its results.
interface bs_normalizer_if #(
    parameter int DATA_W  = 32,
    parameter int SHIFT_W = $clog2(DATA_W)
) ();

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  data_in;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  data_out;
    logic [SHIFT_W-1:0] shift_amt;
    logic               zero;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, shift_amt, zero
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, shift_amt, zero
    );

endinterface

// File: rtl/bs_norm_stage.sv
// One binary-search step of the leading-zero count: if the top 2^k bits are all zero,
// the word is shifted left by 2^k and hit is raised.
module bs_norm_stage
    import bs_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHIFT_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]  w,
    input  logic [SHIFT_W-1:0] k,
    output logic [DATA_W-1:0]  w_out,
    output logic               hit
);

    logic [SHIFT_W-1:0] amt;
    logic [DATA_W-1:0]  top_mask;

    always_comb begin
        amt      = SHIFT_W'(1) << k;
        top_mask = ~({DATA_W{1'b1}} >> amt);
        hit      = (w & top_mask) == '0;
        w_out    = hit ? (w << amt) : w;
    end

endmodule

// File: rtl/bs_normalizer.sv
// Multi-cycle normalizer: left-justifies a word and reports the shift amount used.
// Define BS_NORM_EARLY_EXIT_EN to skip the search for words with MSB set or all zeros.
module bs_normalizer
    import bs_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHIFT_W = $clog2(DATA_W)
) (
    input  logic        clk,
    input  logic        reset,
    bs_normalizer_if.slave bus
);

    bs_norm_state_t     state_q, state_d;
    logic [DATA_W-1:0]  w_q, w_d;
    logic [SHIFT_W-1:0] acc_q, acc_d;
    logic [SHIFT_W-1:0] k_q, k_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [SHIFT_W-1:0] shift_amt_q, shift_amt_d;
    logic               zero_q, zero_d;

    logic [DATA_W-1:0]  stage_w;
    logic               stage_hit;

    bs_norm_stage #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_stage (
        .w     (w_q),
        .k     (k_q),
        .w_out (stage_w),
        .hit   (stage_hit)
    );

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        acc_d       = acc_q;
        k_d         = k_q;
        data_out_d  = data_out_q;
        shift_amt_d = shift_amt_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    w_d     = bus.data_in;
                    acc_d   = '0;
                    k_d     = SHIFT_W'(SHIFT_W - 1);
                    state_d = SHIFT;
`ifdef BS_NORM_EARLY_EXIT_EN
                    if (bus.data_in[DATA_W-1] || (bus.data_in == '0)) begin
                        state_d     = DONE;
                        data_out_d  = bus.data_in;
                        shift_amt_d = bus.data_in[DATA_W-1] ? '0 : SHIFT_W'(DATA_W - 1);
                        zero_d      = !bus.data_in[DATA_W-1];
                    end
`endif
                end
            end
            SHIFT: begin
                w_d = stage_w;
                if (stage_hit) begin
                    acc_d = acc_q + (SHIFT_W'(1) << k_q);
                end
                // The last stage commits straight into the output registers.
                if (k_q == '0) begin
                    state_d     = DONE;
                    data_out_d  = stage_w;
                    shift_amt_d = acc_d;
                    zero_d      = (stage_w == '0);
                end else begin
                    k_d = k_q - SHIFT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            data_out_q  <= '0;
            shift_amt_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            data_out_q  <= data_out_d;
            shift_amt_q <= shift_amt_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.data_out  = data_out_q;
    assign bus.shift_amt = shift_amt_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_bs_normalizer.sv
// Directed and random-word bench for bs_normalizer; latency expectations follow
// BS_NORM_EARLY_EXIT_EN when it is defined.
module tb_bs_normalizer;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    bs_normalizer_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus ();

    bs_normalizer #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference leading-zero count; an all-zero word reports DATA_W-1 like the hardware.
    function automatic int ref_lz(input logic [DATA_W-1:0] d);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (d[i]) return DATA_W - 1 - i;
        end
        return DATA_W - 1;
    endfunction

    function automatic int ref_lat(input logic [DATA_W-1:0] d);
`ifdef BS_NORM_EARLY_EXIT_EN
        if (d[DATA_W-1] || d == '0) return 1;
`endif
        return SHIFT_W + 1;
    endfunction

    // Presents a word at a falling edge, counts rising edges (accept edge included)
    // until out_valid, then checks the result. Leaves the block in DONE.
    task automatic apply_stimulus(input logic [DATA_W-1:0] d, input string tag);
        int lat;
        logic [DATA_W-1:0] exp_out;
        exp_out = d << ref_lz(d);
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".out_valid"}, bus.out_valid, 1'b1);
        check({tag, ".latency"}, lat, ref_lat(d));
        check({tag, ".data_out"}, bus.data_out, exp_out);
        check({tag, ".shift_amt"}, bus.shift_amt, ref_lz(d));
        check({tag, ".zero"}, bus.zero, (d == '0));
    endtask

    // Holds out_ready low for some cycles, checking the result stays put, then consumes it.
    task automatic check_output(input logic [DATA_W-1:0] d, input int stall, input string tag);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, bus.out_valid, 1'b1);
            check({tag, ".hold_data"}, bus.data_out, d << ref_lz(d));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".idle_in_ready"}, bus.in_ready, 1'b1);
        check({tag, ".idle_out_valid"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;

        #1;
        check("reset.in_ready", bus.in_ready, 1'b0);
        check("reset.out_valid", bus.out_valid, 1'b0);
        check("reset.data_out", bus.data_out, 32'h0);
        check("reset.shift_amt", bus.shift_amt, 5'd0);
        check("reset.zero", bus.zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset.in_ready", bus.in_ready, 1'b1);

        apply_stimulus(32'h0000_0001, "lsb");
        check("lsb.const_data", bus.data_out, 32'h8000_0000);
        check("lsb.const_amt", bus.shift_amt, 5'd31);
        check_output(32'h0000_0001, 0, "lsb");

        apply_stimulus(32'h0001_2345, "mid");
        check("mid.const_data", bus.data_out, 32'h91A2_8000);
        check("mid.const_amt", bus.shift_amt, 5'd15);
        check_output(32'h0001_2345, 2, "mid");

        apply_stimulus(32'h8000_0000, "msb");
        check("msb.const_amt", bus.shift_amt, 5'd0);
        check_output(32'h8000_0000, 0, "msb");

        apply_stimulus(32'h0000_0000, "zero");
        check("zero.const_amt", bus.shift_amt, 5'd31);
        check("zero.const_flag", bus.zero, 1'b1);
        check_output(32'h0000_0000, 1, "zero");

        apply_stimulus(32'h0000_0F00, "bp");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = $urandom();
            @(negedge clk);
            check("bp.in_ready", bus.in_ready, 1'b0);
            check("bp.out_valid", bus.out_valid, 1'b1);
            check("bp.data_out", bus.data_out, 32'hF000_0000);
            check("bp.shift_amt", bus.shift_amt, 5'd20);
        end
        bus.data_in   = 32'h0000_0001;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.release_in_ready", bus.in_ready, 1'b1);
        apply_stimulus(32'h0000_0001, "bp_next");
        check_output(32'h0000_0001, 0, "bp_next");

        bus.in_valid = 1'b1;
        bus.data_in  = 32'h00F0_0000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.out_valid", bus.out_valid, 1'b0);
        check("rst_mid.in_ready", bus.in_ready, 1'b0);
        check("rst_mid.data_out", bus.data_out, 32'h0);
        check("rst_mid.shift_amt", bus.shift_amt, 5'd0);
        check("rst_mid.zero", bus.zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.release_in_ready", bus.in_ready, 1'b1);
        apply_stimulus(32'h0000_0100, "after_rst");
        check("after_rst.const_amt", bus.shift_amt, 5'd23);
        check("after_rst.const_data", bus.data_out, 32'h8000_0000);
        check_output(32'h0000_0100, 0, "after_rst");

        for (int n = 0; n < 1000; n++) begin
            w = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 49) == 0) w = '0;
            if ($urandom_range(0, 19) == 0) w = w | 32'h8000_0000;
            apply_stimulus(w, "rand");
            check_output(w, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
